time_of_day_counter: RTL and testbench
======================================

TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: tick  input  1  one-cycle 1 Hz advance pulse from the tick generator.
REQ-004 SHALL have port: mode_btn  input  1  one-cycle pulse, pre-debounced; cycles run/set modes.
REQ-005 SHALL have port: inc_btn  input  1  one-cycle pulse, pre-debounced; increments the field selected in set mode.
REQ-006 SHALL have ports: hours_bcd, mins_bcd, secs_bcd  output  8 each  registered two-digit BCD, tens in [7:4], units in [3:0].
REQ-007 SHALL have port: pm  output  1  registered PM flag.
REQ-008 SHALL have ports: set_hr, set_min  output  1 each  registered, high while in SET_HR / SET_MIN.
REQ-009 SHALL have port: day_wrap  output  1  registered one-cycle pulse on midnight rollover.

Function
REQ-010 SHALL implement states RUN, SET_HR and SET_MIN; mode_btn moves RUN->SET_HR->SET_MIN->RUN; no other transitions.
REQ-011 In RUN, tick SHALL advance secs by one; 59->00 carries to mins; mins 59->00 carries to hours; all outputs update on the edge where tick is sampled (one-cycle latency).
REQ-012 24-hour build: hours SHALL count 00..23; 23:59:59 + tick -> 00:00:00 with day_wrap high for exactly one cycle; pm held 0.
REQ-013 Each BCD digit SHALL stay in 0..9; any carry SHALL propagate through all fields in the same cycle.
REQ-014 Entering SET_HR SHALL clear secs to 00 on that edge.
REQ-015 In SET_HR, inc_btn SHALL increment hours with wrap and no carry into other fields; in SET_MIN, inc_btn SHALL increment mins 59->00 with no carry into hours.
REQ-016 tick SHALL be ignored in SET_HR and SET_MIN; secs holds at 00.
REQ-017 day_wrap SHALL never assert from set-mode increments.
REQ-018 Simultaneous mode_btn and inc_btn: mode transition SHALL be taken and inc_btn discarded.
REQ-019 Simultaneous mode_btn and tick in RUN: transition to SET_HR and secs cleared; tick discarded.
REQ-020 Simultaneous mode_btn and tick in SET_MIN: return to RUN; tick discarded; counting resumes from the next tick.
REQ-021 inc_btn in RUN SHALL have no effect.

Reset
REQ-022 reset SHALL force state RUN, set_hr=0, set_min=0, day_wrap=0, secs=00, mins=00, and hours/pm per REQ-024; reset takes priority over all inputs, including mid-increment and mid-set.

Configuration
REQ-023 Macro CLOCK_TWELVE_HOUR_EN, when undefined, SHALL give the 24-hour behaviour of REQ-012 with pm tied 0.
REQ-024 With CLOCK_TWELVE_HOUR_EN defined: hours SHALL run 12,01..11 and reset to 12:00:00 with pm=0; 11->12 SHALL toggle pm; day_wrap SHALL pulse on 11:59:59 PM -> 12:00:00 AM; in SET_HR, inc_btn SHALL wrap 11->12 and toggle pm.

Structure
REQ-025 Shared package clock_pkg SHALL hold the state enumeration, BCD field limits (59, 23, 12) and the reset time constants.
REQ-026 Sub-module bcd_mod_counter SHALL be used for each field: two-digit BCD, parameterised min/max, with inc input, load/clear, and combinational carry-out at max; instantiated three times.

Verification
REQ-027 reset, then 60 ticks -> 00:01:00; day_wrap stays 0 throughout.
REQ-028 Preset 23:59:58 via set mode, then 2 ticks -> 23:59:59 then 00:00:00, day_wrap high for exactly one cycle on the second tick.
REQ-029 At 10:20:35: mode_btn -> set_hr=1, secs=00; 14 inc_btn -> hours 00; mode_btn, then 45 inc_btn -> mins 05, hours 00; ticks in set mode -> no change.
REQ-030 Same-cycle mode_btn+inc_btn in SET_HR -> state SET_MIN, hours unchanged; same-cycle mode_btn+tick in RUN -> SET_HR, secs 00.
REQ-031 reset asserted in SET_MIN after 3 inc_btn -> next cycle RUN, 00:00:00 (12:00:00, pm=0 with CLOCK_TWELVE_HOUR_EN).
REQ-032 CLOCK_TWELVE_HOUR_EN build: 11:59:59 pm=0 + tick -> 12:00:00 pm=1; 11:59:59 pm=1 + tick -> 12:00:00 pm=0 and day_wrap pulse.

Source files
------------

// File: rtl/time_of_day_counter_pkg.sv
// Shared clock definitions: mode enumeration, BCD field limits, reset time.
// Pure definitions, no latency; no flow control.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_e;

    localparam logic [7:0] SEC_MIN_BCD  = 8'h00;
    localparam logic [7:0] SEC_MAX_BCD  = 8'h59;
    localparam logic [7:0] MIN_MIN_BCD  = 8'h00;
    localparam logic [7:0] MIN_MAX_BCD  = 8'h59;
    localparam logic [7:0] HR24_MIN_BCD = 8'h00;
    localparam logic [7:0] HR24_MAX_BCD = 8'h23;
    localparam logic [7:0] HR12_MIN_BCD = 8'h01;
    localparam logic [7:0] HR12_MAX_BCD = 8'h12;
    // 11 -> 12 is where the 12-hour clock flips AM/PM.
    localparam logic [7:0] HR12_PM_FLIP = 8'h11;

    localparam logic [7:0] RST_SEC_BCD  = 8'h00;
    localparam logic [7:0] RST_MIN_BCD  = 8'h00;
    localparam logic [7:0] RST_HR24_BCD = 8'h00;
    localparam logic [7:0] RST_HR12_BCD = 8'h12;

    function automatic logic [7:0] bcd_next(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/time_of_day_counter_bcd.sv
// Two-digit BCD counter wrapping MAX_VAL -> MIN_VAL; max_o flags the wrap point.
// Value updates one cycle after inc_i/clr_i; no backpressure, inc_i always accepted.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MIN_VAL = 8'h00,
    parameter logic [7:0] MAX_VAL = 8'h59,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [7:0] val_o,
    output logic       max_o
);

    logic [7:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (clr_i) begin
            val_d = MIN_VAL;
        end else if (inc_i) begin
            val_d = (val_q == MAX_VAL) ? MIN_VAL : bcd_next(val_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= RST_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;
    assign max_o = (val_q == MAX_VAL);

endmodule

// File: rtl/time_of_day_counter.sv
// Time-of-day clock with run/set modes; 12-hour mode under CLOCK_TWELVE_HOUR_EN.
// Outputs update on the edge sampling tick/inc_btn/mode_btn; no backpressure.
module time_of_day_counter
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] hours_bcd,
    output logic [7:0] mins_bcd,
    output logic [7:0] secs_bcd,
    output logic       pm,
    output logic       set_hr,
    output logic       set_min,
    output logic       day_wrap
);

`ifdef CLOCK_TWELVE_HOUR_EN
    localparam logic [7:0] HR_MIN = HR12_MIN_BCD;
    localparam logic [7:0] HR_MAX = HR12_MAX_BCD;
    localparam logic [7:0] HR_RST = RST_HR12_BCD;
`else
    localparam logic [7:0] HR_MIN = HR24_MIN_BCD;
    localparam logic [7:0] HR_MAX = HR24_MAX_BCD;
    localparam logic [7:0] HR_RST = RST_HR24_BCD;
`endif

    state_e     state_q, state_d;
    logic       set_hr_q, set_min_q, pm_q, pm_d, day_wrap_q, day_wrap_d;
    logic [7:0] secs, mins, hours;
    logic       sec_max, min_max, hr_max;
    logic       in_run, in_set_hr, in_set_min;
    logic       sec_inc, sec_clr, sec_carry, min_inc, min_carry, hr_inc;

    assign in_run     = (state_q == ST_RUN);
    assign in_set_hr  = (state_q == ST_SET_HR);
    assign in_set_min = (state_q == ST_SET_MIN);

    always_comb begin
        state_d = state_q;
        if (mode_btn) begin
            case (state_q)
                ST_RUN:    state_d = ST_SET_HR;
                ST_SET_HR: state_d = ST_SET_MIN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // mode_btn wins over tick and inc_btn in the same cycle.
    assign sec_inc   = in_run & tick & ~mode_btn;
    assign sec_clr   = in_run & mode_btn;
    assign sec_carry = sec_inc & sec_max;
    assign min_carry = sec_carry & min_max;
    assign min_inc   = sec_carry | (in_set_min & inc_btn & ~mode_btn);
    assign hr_inc    = min_carry | (in_set_hr & inc_btn & ~mode_btn);

`ifdef CLOCK_TWELVE_HOUR_EN
    assign pm_d       = pm_q ^ (hr_inc & (hours == HR12_PM_FLIP));
    assign day_wrap_d = min_carry & (hours == HR12_PM_FLIP) & pm_q;
`else
    assign pm_d       = 1'b0;
    assign day_wrap_d = min_carry & hr_max;
`endif

    bcd_mod_counter #(.MIN_VAL(SEC_MIN_BCD), .MAX_VAL(SEC_MAX_BCD), .RST_VAL(RST_SEC_BCD)) u_secs (
        .clk(clk), .reset(reset), .inc_i(sec_inc), .clr_i(sec_clr), .val_o(secs), .max_o(sec_max)
    );

    bcd_mod_counter #(.MIN_VAL(MIN_MIN_BCD), .MAX_VAL(MIN_MAX_BCD), .RST_VAL(RST_MIN_BCD)) u_mins (
        .clk(clk), .reset(reset), .inc_i(min_inc), .clr_i(1'b0), .val_o(mins), .max_o(min_max)
    );

    bcd_mod_counter #(.MIN_VAL(HR_MIN), .MAX_VAL(HR_MAX), .RST_VAL(HR_RST)) u_hours (
        .clk(clk), .reset(reset), .inc_i(hr_inc), .clr_i(1'b0), .val_o(hours), .max_o(hr_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            set_hr_q   <= 1'b0;
            set_min_q  <= 1'b0;
            pm_q       <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_hr_q   <= (state_d == ST_SET_HR);
            set_min_q  <= (state_d == ST_SET_MIN);
            pm_q       <= pm_d;
            day_wrap_q <= day_wrap_d;
        end
    end

    assign hours_bcd = hours;
    assign mins_bcd  = mins;
    assign secs_bcd  = secs;
    assign pm        = pm_q;
    assign set_hr    = set_hr_q;
    assign set_min   = set_min_q;
    assign day_wrap  = day_wrap_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: directed table, corner sequences, random run vs a seconds-of-day model.
module tb_time_of_day_counter;

`ifdef CLOCK_TWELVE_HOUR_EN
    localparam bit         TWELVE = 1'b1;
    localparam logic [7:0] RH     = 8'h12;
    localparam logic [7:0] HLAST  = 8'h11;
`else
    localparam bit         TWELVE = 1'b0;
    localparam logic [7:0] RH     = 8'h00;
    localparam logic [7:0] HLAST  = 8'h23;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0, tick = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0;
    logic [7:0] hours_bcd, mins_bcd, secs_bcd;
    logic       pm, set_hr, set_min, day_wrap;

    time_of_day_counter dut (
        .clk(clk), .reset(reset), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .hours_bcd(hours_bcd), .mins_bcd(mins_bcd), .secs_bcd(secs_bcd),
        .pm(pm), .set_hr(set_hr), .set_min(set_min), .day_wrap(day_wrap)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: mode (0 run, 1 set hours, 2 set minutes) and seconds since midnight.
    int m_mode = 0;
    int m_tod  = 0;
    bit m_wrap = 1'b0;

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [27:0] model_vec();
        int h, dh;
        h  = m_tod / 3600;
        dh = TWELVE ? ((h % 12 == 0) ? 12 : h % 12) : h;
        return {bcd2(dh), bcd2((m_tod / 60) % 60), bcd2(m_tod % 60),
                TWELVE && (h >= 12), m_mode == 1, m_mode == 2, m_wrap};
    endfunction

    function automatic logic [27:0] dut_vec();
        return {hours_bcd, mins_bcd, secs_bcd, pm, set_hr, set_min, day_wrap};
    endfunction

    task automatic model_step(input bit r, input bit md, input bit in, input bit tk);
        int h, m;
        m_wrap = 1'b0;
        if (r) begin
            m_mode = 0;
            m_tod  = 0;
        end else if (md) begin
            if (m_mode == 0) begin
                m_mode = 1;
                m_tod  = m_tod - (m_tod % 60);
            end else if (m_mode == 1) begin
                m_mode = 2;
            end else begin
                m_mode = 0;
            end
        end else if (m_mode == 0 && tk) begin
            m_tod = m_tod + 1;
            if (m_tod == 86400) begin
                m_tod  = 0;
                m_wrap = 1'b1;
            end
        end else if (m_mode == 1 && in) begin
            h     = m_tod / 3600;
            m_tod = ((h + 1) % 24) * 3600 + (m_tod % 3600);
        end else if (m_mode == 2 && in) begin
            m     = (m_tod / 60) % 60;
            m_tod = m_tod - m * 60 + ((m + 1) % 60) * 60;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, update the model, compare all outputs just after the edge.
    task automatic step(input bit r, input bit md, input bit in, input bit tk);
        reset    = r;
        mode_btn = md;
        inc_btn  = in;
        tick     = tk;
        @(posedge clk);
        model_step(r, md, in, tk);
        #1;
        chk("model {hr,min,sec,pm,set_hr,set_min,wrap}", {4'd0, dut_vec()}, {4'd0, model_vec()});
        reset    = 1'b0;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        tick     = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0);
    endtask

    task automatic mode();
        step(0, 1, 0, 0);
    endtask

    typedef struct {
        bit         r, md, in, tk;
        logic [7:0] h, m, s;
        bit         shr, smin, dw;
    } vec_t;

    vec_t tbl[13];
    int   wrap_seen;

    initial begin
        tbl[0]  = '{1, 0, 0, 0, RH,    8'h00, 8'h00, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, RH,    8'h00, 8'h00, 1, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 8'h01, 8'h00, 8'h00, 1, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 8'h02, 8'h00, 8'h00, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 1, 8'h02, 8'h00, 8'h00, 1, 0, 0};
        tbl[5]  = '{0, 1, 1, 0, 8'h02, 8'h00, 8'h00, 0, 1, 0};
        tbl[6]  = '{0, 0, 1, 0, 8'h02, 8'h01, 8'h00, 0, 1, 0};
        tbl[7]  = '{0, 0, 0, 1, 8'h02, 8'h01, 8'h00, 0, 1, 0};
        tbl[8]  = '{0, 1, 0, 1, 8'h02, 8'h01, 8'h00, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 8'h02, 8'h01, 8'h01, 0, 0, 0};
        tbl[10] = '{0, 0, 1, 0, 8'h02, 8'h01, 8'h01, 0, 0, 0};
        tbl[11] = '{0, 1, 0, 1, 8'h02, 8'h01, 8'h00, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 0, RH,    8'h00, 8'h00, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].md, tbl[i].in, tbl[i].tk);
            chk($sformatf("table row %0d", i), {4'd0, dut_vec()},
                {4'd0, tbl[i].h, tbl[i].m, tbl[i].s, 1'b0, tbl[i].shr, tbl[i].smin, tbl[i].dw});
        end

        // 60 ticks from reset reach one minute, never wrapping the day.
        step(1, 0, 0, 0);
        wrap_seen = 0;
        for (int i = 0; i < 60; i++) begin
            step(0, 0, 0, 1);
            if (day_wrap) wrap_seen++;
        end
        chk("sixty ticks time", {8'd0, hours_bcd, mins_bcd, secs_bcd}, {8'd0, RH, 8'h01, 8'h00});
        chk("sixty ticks no wrap", wrap_seen, 0);

        // Preset last second of the day, then roll over midnight.
        step(1, 0, 0, 0);
        mode(); incs(23); mode(); incs(59); mode();
        ticks(58);
        ticks(1);
        chk("pre-midnight", {7'd0, hours_bcd, mins_bcd, secs_bcd, pm}, {7'd0, HLAST, 8'h59, 8'h59, TWELVE});
        chk("pre-midnight wrap low", {31'd0, day_wrap}, 0);
        ticks(1);
        chk("midnight time", {8'd0, hours_bcd, mins_bcd, secs_bcd}, {8'd0, RH, 8'h00, 8'h00});
        chk("midnight wrap pulse", {31'd0, day_wrap}, 1);
        step(0, 0, 0, 0);
        chk("wrap pulse one cycle", {31'd0, day_wrap}, 0);

        // 10:20:35, enter set mode, wrap hours and walk minutes.
        step(1, 0, 0, 0);
        mode(); incs(10); mode(); incs(20); mode();
        ticks(35);
        chk("10:20:35", {8'd0, hours_bcd, mins_bcd, secs_bcd}, {8'd0, 8'h10, 8'h20, 8'h35});
        mode();
        chk("enter set_hr", {7'd0, set_hr, secs_bcd, 8'd0, 8'd0}, {7'd0, 1'b1, 8'h00, 8'd0, 8'd0});
        incs(14);
        chk("hours wrapped", {24'd0, hours_bcd}, {24'd0, RH});
        mode(); incs(45);
        ticks(3);
        chk("set_min result", {8'd0, hours_bcd, mins_bcd, secs_bcd}, {8'd0, RH, 8'h05, 8'h00});
        chk("set_min no wrap", {31'd0, day_wrap}, 0);

        // Reset in the middle of setting minutes.
        mode(); mode(); mode(); incs(3);
        step(1, 0, 0, 0);
        chk("reset mid-set", {4'd0, dut_vec()}, {4'd0, RH, 8'h00, 8'h00, 4'b0000});

`ifdef CLOCK_TWELVE_HOUR_EN
        // Noon: 11:59:59 AM + tick -> 12:00:00 PM without a day wrap.
        mode(); incs(11); mode(); incs(59); mode();
        ticks(59);
        ticks(1);
        chk("noon", {7'd0, hours_bcd, mins_bcd, secs_bcd, day_wrap}, {7'd0, 8'h12, 8'h00, 8'h00, 1'b0});
        chk("noon pm", {31'd0, pm}, 1);
`endif

        // Random traffic against the model.
        step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
